// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK flop bank controller: command codes and FSM states.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-low clear; {j,k} uses the op_t encoding.
module jk_ff
  import jk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case (op_t'({j, k}))
        OP_HOLD: q <= q;
        OP_RST:  q <= 1'b0;
        OP_SET:  q <= 1'b1;
        OP_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters one JK command at a time on a WIDTH-flop bank.
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IW*NREQ-1:0]   idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     q
);

  localparam int PW = $clog2(NREQ);

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   win_lat;
  logic [1:0]      op_win;
  logic [1:0]      op_lat;
  logic [IW-1:0]   idx_win;
  logic [IW-1:0]   idx_lat;
  logic            idx_oor;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  // Scan from the farthest candidate to the nearest so the requester closest
  // to ptr (inclusive) is the last assignment and therefore the winner.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   ptr);
    logic [PW-1:0] w;
    int            c;
    w = ptr;
    for (int n = NREQ - 1; n >= 0; n--) begin
      c = (int'(ptr) + n) % NREQ;
      if (r[c]) w = PW'(c);
    end
    return w;
  endfunction

  assign win     = rr_pick(req, rr_ptr);
  assign idx_oor = int'(idx_lat) >= WIDTH;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    op_win  = '0;
    idx_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        op_win  = op[2*i +: 2];
        idx_win = idx[IW*i +: IW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      win_lat <= '0;
      op_lat  <= OP_HOLD;
      idx_lat <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            op_lat  <= op_win;
            idx_lat <= idx_win;
            win_lat <= win;
            gnt     <= NREQ'(1) << win;
            busy    <= 1'b1;
            state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          done  <= 1'b1;
          err   <= idx_oor;
          state <= ST_ACK;
        end
        ST_ACK: begin
          rr_ptr <= (win_lat == PW'(NREQ - 1)) ? '0 : win_lat + PW'(1);
          gnt    <= '0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Only the addressed flop sees the command, and only for the single DRIVE edge;
  // an out-of-range index matches nothing, leaving the bank untouched.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (state == ST_DRIVE) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (idx_lat == IW'(i)) begin
          j_vec[i] = op_lat[1];
          k_vec[i] = op_lat[0];
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jk_ff u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[g]),
      .k     (k_vec[g]),
      .q     (q[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed results, per-DUT monitors pop on each done pulse.
module tb_jk_bank_arbiter;
  import jk_ctrl_pkg::*;

  typedef struct {
    logic [3:0] gnt;
    logic       err;
    logic [7:0] q;
    int         gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_a, req_b;
  logic [7:0]  op_a, op_b;
  logic [11:0] idx_a, idx_b;
  logic [3:0]  gnt_a, gnt_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [7:0]  q_a;
  logic [5:0]  q_b;

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .op(op_a), .idx(idx_a),
    .gnt(gnt_a), .busy(busy_a), .done(done_a), .err(err_a), .q(q_a)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .op(op_b), .idx(idx_b),
    .gnt(gnt_b), .busy(busy_b), .done(done_b), .err(err_b), .q(q_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic compare(input string p, input exp_t e, input logic [3:0] g,
                         input logic [3:0] pg, input logic er, input logic [7:0] qv,
                         input logic pd, input logic bz, input int gap);
    check({p, "_gnt"}, g, e.gnt);
    check({p, "_gnt_held"}, pg, e.gnt);
    check({p, "_err"}, er, e.err);
    check({p, "_q"}, qv, e.q);
    check({p, "_done_single"}, pd, 1'b0);
    check({p, "_busy"}, bz, 1'b1);
    if (e.gap != 0) check({p, "_done_gap"}, gap, e.gap);
  endtask

  // Monitor for the WIDTH=8 instance.
  logic [3:0] pgnt_a = '0;
  logic       pdone_a = 1'b0;
  logic [7:0] last_q_a = '0;
  int         cyc_a = 0, last_cyc_a = 0;
  always @(negedge clk) begin
    exp_t ea;
    cyc_a++;
    if (!reset) begin
      last_q_a = '0;
    end else if (done_a) begin
      if (qa.size() == 0) fail("a_unexpected_done", 1, 0);
      else begin
        ea = qa.pop_front();
        compare("a", ea, gnt_a, pgnt_a, err_a, q_a, pdone_a, busy_a, cyc_a - last_cyc_a);
        last_q_a = ea.q;
      end
      last_cyc_a = cyc_a;
    end else if (busy_a) begin
      check("a_q_before_update", q_a, last_q_a);
    end
    pgnt_a  = gnt_a;
    pdone_a = done_a;
  end

  // Monitor for the WIDTH=6 instance.
  logic [3:0] pgnt_b = '0;
  logic       pdone_b = 1'b0;
  logic [7:0] last_q_b = '0;
  int         cyc_b = 0, last_cyc_b = 0;
  always @(negedge clk) begin
    exp_t eb;
    cyc_b++;
    if (!reset) begin
      last_q_b = '0;
    end else if (done_b) begin
      if (qb.size() == 0) fail("b_unexpected_done", 1, 0);
      else begin
        eb = qb.pop_front();
        compare("b", eb, gnt_b, pgnt_b, err_b, {2'b00, q_b}, pdone_b, busy_b, cyc_b - last_cyc_b);
        last_q_b = eb.q;
      end
      last_cyc_b = cyc_b;
    end else if (busy_b) begin
      check("b_q_before_update", {2'b00, q_b}, last_q_b);
    end
    pgnt_b  = gnt_b;
    pdone_b = done_b;
  end

  task automatic push(input bit sel, input logic [3:0] g, input logic e,
                      input logic [7:0] qv, input int gap);
    exp_t x;
    x.gnt = g; x.err = e; x.q = qv; x.gap = gap;
    if (sel) qb.push_back(x);
    else     qa.push_back(x);
  endtask

  task automatic wait_done(input bit sel, input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) seen++;
    end
    if (seen < n) fail(sel ? "b_done_timeout" : "a_done_timeout", seen, n);
  endtask

  // One isolated command; op/idx are scrambled and req dropped right after the
  // grant edge, which must not disturb the operation already latched.
  task automatic do_op(input bit sel, input int r, input logic [1:0] opv, input int idxv,
                       input logic [3:0] eg, input logic ee, input logic [7:0] eq);
    logic [2:0] iv;
    iv = idxv[2:0];
    @(negedge clk);
    push(sel, eg, ee, eq, 0);
    if (sel) begin req_b[r] = 1'b1; op_b[2*r +: 2] = opv; idx_b[3*r +: 3] = iv; end
    else     begin req_a[r] = 1'b1; op_a[2*r +: 2] = opv; idx_a[3*r +: 3] = iv; end
    @(posedge clk);
    #1;
    if (sel) begin req_b[r] = 1'b0; op_b[2*r +: 2] = ~opv; idx_b[3*r +: 3] = iv ^ 3'd1; end
    else     begin req_a[r] = 1'b0; op_a[2*r +: 2] = ~opv; idx_a[3*r +: 3] = iv ^ 3'd1; end
    wait_done(sel, 1, 10);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req_b = '0; op_b = '0; idx_b = '0;
    // All requesters asserted through reset, each setting its own index.
    req_a = 4'b1111;
    op_a  = {OP_SET, OP_SET, OP_SET, OP_SET};
    idx_a = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_q", q_a, 8'h00);
      check("rst_gnt", gnt_a, 4'h0);
      check("rst_done", done_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
    end
    push(0, 4'b0001, 1'b0, 8'h01, 0);
    push(0, 4'b0010, 1'b0, 8'h03, 3);
    push(0, 4'b0100, 1'b0, 8'h07, 3);
    push(0, 4'b1000, 1'b0, 8'h0F, 3);
    push(0, 4'b0001, 1'b0, 8'h0F, 3);
    reset = 1'b1;
    wait_done(0, 5, 40);
    req_a = '0;
    @(negedge clk);

    // Isolated commands from a fresh bank; rr_ptr starts at 0.
    pulse_reset();
    do_op(0, 0, OP_SET,  3, 4'b0001, 1'b0, 8'h08);
    do_op(0, 2, OP_TGL,  5, 4'b0100, 1'b0, 8'h28);
    do_op(0, 2, OP_TGL,  5, 4'b0100, 1'b0, 8'h08);
    do_op(0, 2, OP_RST,  3, 4'b0100, 1'b0, 8'h00);
    do_op(0, 1, OP_SET,  7, 4'b0010, 1'b0, 8'h80);
    do_op(0, 1, OP_HOLD, 7, 4'b0010, 1'b0, 8'h80);

    // Reset during DRIVE abandons the command and rewinds rr_ptr.
    @(negedge clk);
    req_a[3] = 1'b1; op_a[7:6] = OP_SET; idx_a[11:9] = 3'd6;
    @(posedge clk);
    @(negedge clk);
    check("mid_gnt_drive", gnt_a, 4'b1000);
    #2;
    reset = 1'b0;
    #1;
    check("mid_gnt_clr", gnt_a, 4'h0);
    check("mid_busy_clr", busy_a, 1'b0);
    check("mid_done_clr", done_a, 1'b0);
    check("mid_q_clr", q_a, 8'h00);
    req_a = 4'b1111;
    op_a  = {OP_SET, OP_SET, OP_SET, OP_SET};
    idx_a = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_no_done", done_a, 1'b0);
      check("mid_q6", q_a[6], 1'b0);
    end
    push(0, 4'b0001, 1'b0, 8'h01, 0);
    reset = 1'b1;
    wait_done(0, 1, 10);
    req_a = '0;
    @(negedge clk);

    // WIDTH=6 instance: last valid index, out-of-range no-op, rr_ptr advance.
    do_op(1, 0, OP_SET, 5, 4'b0001, 1'b0, 8'h20);
    do_op(1, 1, OP_SET, 7, 4'b0010, 1'b1, 8'h20);
    @(negedge clk);
    push(1, 4'b0100, 1'b0, 8'h24, 0);
    push(1, 4'b0001, 1'b0, 8'h25, 3);
    req_b = 4'b0101;
    op_b  = {OP_HOLD, OP_SET, OP_HOLD, OP_SET};
    idx_b = {3'd0, 3'd2, 3'd0, 3'd0};
    wait_done(1, 2, 20);
    req_b = '0;
    do_op(1, 3, OP_TGL, 6, 4'b1000, 1'b1, 8'h25);

    repeat (4) @(negedge clk);
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
